// File: rtl/host_handshake_ctrl.sv
// Host/core handshake and shared-SRAM port controller for the NCC search core.
// Optional read watchdog is enabled by defining HS_WATCHDOG_EN.
module host_handshake_ctrl #(
  parameter int unsigned         ADDR_W      = 21,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         SET_W       = 8,
  parameter int unsigned         RES_WORDS   = 4,
  parameter logic [ADDR_W-1:0]   RESULT_BASE = 'h03CF96,
  parameter logic [ADDR_W-1:0]   FLAG_ADDR   = 'h0,
  parameter logic [ADDR_W-1:0]   DONE_ADDR   = 'h7FFFE,
  parameter logic [DATA_W-1:0]   START_CODE  = 'h0001_0000,
  parameter logic [DATA_W-1:0]   ACK_CODE    = 'h2,
  parameter logic [DATA_W-1:0]   DONE_CODE   = 'h4,
  parameter int unsigned         WDOG_CYCLES = 1024,
  localparam int unsigned        IDX_W       = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] host_flag,
  output logic              flag_we,
  output logic [DATA_W-1:0] flag_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              core_start,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [SET_W-1:0]  core_set,
  input  logic [IDX_W-1:0]  core_wr_idx,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_set_done,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              frame_sel,
  output logic [SET_W-1:0]  sets_done,
  output logic              err
);

  localparam int unsigned NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RUN, RD_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                start_hit, rd_accept, rd_done, idx_bad, wdog_hit;
  logic [ADDR_W-1:0]   res_addr;

  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NBYTES); i++) r[8*i +: 8] = d[8*(int'(NBYTES)-1-i) +: 8];
    return r;
  endfunction

  // Result slot address; sums wrap at ADDR_W
  assign res_addr = RESULT_BASE
                  + ADDR_W'(ADDR_W'(core_set) * ADDR_W'(RES_WORDS))
                  + ADDR_W'(core_wr_idx);

`ifdef HS_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  // Counts consecutive RD_WAIT cycles; restarts on every new read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wdog_q <= '0;
    else if (state_q == RD_WAIT) wdog_q <= wdog_q + WD_W'(1);
    else                       wdog_q <= '0;
  end
`endif

  // Next state and same-cycle port strobes
  always_comb begin
    state_d    = state_q;
    flag_we    = 1'b0;
    flag_out   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = FLAG_ADDR;
    mem_wdata  = '0;
    core_start = 1'b0;
    start_hit  = 1'b0;
    rd_accept  = 1'b0;
    rd_done    = 1'b0;
    idx_bad    = 1'b0;
    wdog_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_flag == START_CODE) begin
          flag_we   = 1'b1;
          flag_out  = ACK_CODE;
          start_hit = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        core_start = 1'b1;
        if (core_set_done) begin
          state_d = DONE;
        end else if (core_req && core_wr) begin
          mem_addr = res_addr;
          if ({1'b0, core_wr_idx} >= (IDX_W+1)'(RES_WORDS)) begin
            idx_bad = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = bswap(core_wdata);
          end
        end else if (core_req) begin
          mem_req   = 1'b1;
          mem_addr  = core_addr;
          rd_accept = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_addr = rd_addr_q;
        if (mem_rvalid) begin
          rd_done = 1'b1;
          state_d = RUN;
        end
`ifdef HS_WATCHDOG_EN
        else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
          wdog_hit = 1'b1;
          state_d  = RUN;
        end
`endif
      end
      DONE: begin
        flag_we  = 1'b1;
        flag_out = DONE_CODE;
        mem_addr = DONE_ADDR;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered status/read-return outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      core_rdata  <= '0;
      core_rvalid <= 1'b0;
      frame_sel   <= 1'b1;
      sets_done   <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rvalid <= rd_done | wdog_hit;
      if (rd_accept) rd_addr_q <= core_addr;
      if (rd_done)        core_rdata <= bswap(mem_rdata);
      else if (wdog_hit)  core_rdata <= '0;
      if (start_hit) frame_sel <= ~frame_sel;
      if (state_q == DONE) sets_done <= sets_done + SET_W'(1);
      if (idx_bad || wdog_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_host_handshake_ctrl.sv
// Directed self-checking bench for host_handshake_ctrl (default parameters).
module tb_host_handshake_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] host_flag;
  logic        flag_we;
  logic [31:0] flag_out;
  logic        mem_req, mem_we;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        core_start, core_req, core_wr;
  logic [20:0] core_addr;
  logic [7:0]  core_set;
  logic [1:0]  core_wr_idx;
  logic [31:0] core_wdata;
  logic        core_set_done;
  logic [31:0] core_rdata;
  logic        core_rvalid, frame_sel, err;
  logic [7:0]  sets_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  host_handshake_ctrl dut (
    .clk(clk), .rst_n(rst_n), .host_flag(host_flag),
    .flag_we(flag_we), .flag_out(flag_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .core_start(core_start), .core_req(core_req), .core_wr(core_wr),
    .core_addr(core_addr), .core_set(core_set), .core_wr_idx(core_wr_idx),
    .core_wdata(core_wdata), .core_set_done(core_set_done),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .frame_sel(frame_sel), .sets_done(sets_done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen near the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; host_flag = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    core_req = 1'b0; core_wr = 1'b0; core_addr = '0; core_set = '0;
    core_wr_idx = '0; core_wdata = '0; core_set_done = 1'b0;
    tick(); tick(); settle();
    check("rst_frame_sel", 64'(frame_sel), 64'h1);
    check("rst_flag_we", 64'(flag_we), 64'h0);
    check("rst_core_start", 64'(core_start), 64'h0);
    check("rst_sets_done", 64'(sets_done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);

    tick(); rst_n = 1'b1;
    // START acknowledge
    tick(); host_flag = 32'h0001_0000; settle();
    check("start_flag_we", 64'(flag_we), 64'h1);
    check("start_flag_out", 64'(flag_out), 64'h2);
    check("start_mem_addr", 64'(mem_addr), 64'h0);
    check("start_frame_sel_before", 64'(frame_sel), 64'h1);
    tick(); host_flag = '0; settle();
    check("run_frame_sel", 64'(frame_sel), 64'h0);
    check("run_core_start", 64'(core_start), 64'h1);
    check("run_flag_we", 64'(flag_we), 64'h0);

    // Result writes
    core_req = 1'b1; core_wr = 1'b1; core_set = 8'd3; core_wr_idx = 2'd2;
    core_wdata = 32'h1122_3344; settle();
    check("wr_mem_we", 64'(mem_we), 64'h1);
    check("wr_mem_addr", 64'(mem_addr), 64'h03CFA4);
    check("wr_mem_wdata", 64'(mem_wdata), 64'h4433_2211);
    check("wr_mem_req", 64'(mem_req), 64'h0);
    tick(); core_set = 8'd255; core_wr_idx = 2'd3; core_wdata = 32'hA1B2_C3D4; settle();
    check("wr_max_addr", 64'(mem_addr), 64'h03D395);
    check("wr_max_wdata", 64'(mem_wdata), 64'hD4C3_B2A1);

    // Read with 3-cycle memory latency
    tick(); core_wr = 1'b0; core_addr = 21'h100; settle();
    check("rd_mem_req", 64'(mem_req), 64'h1);
    check("rd_mem_addr", 64'(mem_addr), 64'h100);
    tick(); core_req = 1'b0; core_addr = 21'h1F0; settle();
    check("rdw_core_start", 64'(core_start), 64'h0);
    check("rdw_mem_addr", 64'(mem_addr), 64'h100);
    check("rdw_mem_req", 64'(mem_req), 64'h0);
    tick(); tick(); mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD; settle();
    check("rdv_core_rvalid_early", 64'(core_rvalid), 64'h0);
    tick(); mem_rvalid = 1'b0; mem_rdata = '0; settle();
    check("rd_core_rvalid", 64'(core_rvalid), 64'h1);
    check("rd_core_rdata", 64'(core_rdata), 64'hDDCC_BBAA);
    check("rd_back_in_run", 64'(core_start), 64'h1);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; settle();
    check("rd_pulse_end", 64'(core_rvalid), 64'h0);
    tick(); mem_rvalid = 1'b0; settle();
    check("stray_rvalid_ignored", 64'(core_rvalid), 64'h0);
    check("stray_rdata_hold", 64'(core_rdata), 64'hDDCC_BBAA);

    // set_done wins over a coincident request
    core_set_done = 1'b1; core_req = 1'b1; core_wr = 1'b1; settle();
    check("sd_no_mem_we", 64'(mem_we), 64'h0);
    check("sd_no_mem_req", 64'(mem_req), 64'h0);
    tick(); core_set_done = 1'b0; core_wr = 1'b0; settle();
    check("done_flag_we", 64'(flag_we), 64'h1);
    check("done_flag_out", 64'(flag_out), 64'h4);
    check("done_mem_addr", 64'(mem_addr), 64'h7FFFE);
    check("done_no_mem_req", 64'(mem_req), 64'h0);
    tick(); core_wr = 1'b1; settle();
    check("idle_sets_done", 64'(sets_done), 64'h1);
    check("idle_core_start", 64'(core_start), 64'h0);
    check("idle_ignore_req", 64'(mem_we), 64'h0);
    core_req = 1'b0; core_wr = 1'b0;

    // 255 more frames: sets_done wraps, frame_sel toggles each START
    for (int i = 0; i < 255; i++) begin
      tick(); host_flag = 32'h0001_0000;
      tick(); host_flag = '0; core_set_done = 1'b1;
      if (i == 0) begin
        settle();
        check("start2_frame_sel", 64'(frame_sel), 64'h1);
      end
      tick(); core_set_done = 1'b0;
    end
    tick(); settle();
    check("sets_done_wrap", 64'(sets_done), 64'h0);
    check("frame_sel_256", 64'(frame_sel), 64'h1);
    check("err_still_clear", 64'(err), 64'h0);

    // Reset during a pending read; late rvalid ignored
    host_flag = 32'h0001_0000;
    tick(); host_flag = '0; core_req = 1'b1; core_addr = 21'h55;
    tick(); core_req = 1'b0;
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); mem_rvalid = 1'b0; settle();
    check("rstrd_core_rvalid", 64'(core_rvalid), 64'h0);
    check("rstrd_core_rdata", 64'(core_rdata), 64'h0);
    check("rstrd_idle", 64'(core_start), 64'h0);
    check("rstrd_frame_sel", 64'(frame_sel), 64'h1);

    // Read that never completes
    tick(); host_flag = 32'h0001_0000;
    tick(); host_flag = '0; core_req = 1'b1; core_wr = 1'b0; core_addr = 21'h77;
    lat = 0;
    for (int k = 1; k <= 1100 && lat == 0; k++) begin
      tick(); core_req = 1'b0; settle();
      if (core_rvalid) lat = k;
    end
`ifdef HS_WATCHDOG_EN
    check("wdog_latency", 64'(lat), 64'd1025);
    check("wdog_rdata", 64'(core_rdata), 64'h0);
    check("wdog_err", 64'(err), 64'h1);
    check("wdog_back_run", 64'(core_start), 64'h1);
`else
    check("nowdog_no_rvalid", 64'(lat), 64'd0);
    check("nowdog_stays_wait", 64'(core_start), 64'h0);
    check("nowdog_addr_held", 64'(mem_addr), 64'h77);
    check("nowdog_err", 64'(err), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
